// File: rtl/lpif_x8_asym2_pkg.sv
// Shared field map, flit layout and link states for the x8 asym2 master-side LPIF endpoint.
package lpif_x8_asym2_pkg;

    localparam int STATE_W  = 4;
    localparam int PROTID_W = 2;
    localparam int DATA_W   = 128;
    localparam int CRC_W    = 8;
    localparam int FLIT_W   = STATE_W + PROTID_W + DATA_W + CRC_W + 3;

    // Bit offsets of each field inside the 145-bit logic-link word.
    localparam int STATE_LSB     = 0;
    localparam int PROTID_LSB    = 4;
    localparam int DATA_LSB      = 6;
    localparam int DVALID_BIT    = 134;
    localparam int CRC_LSB       = 135;
    localparam int CRC_VALID_BIT = 143;
    localparam int VALID_BIT     = 144;

    // Packed MSB-first, so the declaration order mirrors the field map top-down.
    typedef struct packed {
        logic                valid;
        logic                crc_valid;
        logic [CRC_W-1:0]    crc;
        logic                dvalid;
        logic [DATA_W-1:0]   data;
        logic [PROTID_W-1:0] protid;
        logic [STATE_W-1:0]  state;
    } lpif_flit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } link_st_e;

    // Keeps the payload fields of a flit but drops its three qualifiers.
    function automatic lpif_flit_t clear_qualifiers(input lpif_flit_t f);
        lpif_flit_t r;
        r           = f;
        r.valid     = 1'b0;
        r.dvalid    = 1'b0;
        r.crc_valid = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/lpif_skid2.sv
// Two-entry in-order ready/valid buffer; push and pop may coincide at any occupancy.
module lpif_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         rdy,
    output logic         vld,
    output logic         full,
    output logic         pop,
    output logic [W-1:0] dout
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic         accept_s;

    assign vld  = (count_q != 2'd0);
    assign full = (count_q == 2'd2);
    assign pop  = vld & rdy;
    assign dout = mem0_q;

    // Next occupancy and entry contents; mem0 is always the head.
    always_comb begin
        count_d  = count_q;
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        accept_s = push & (~full | pop);
        if (clr) begin
            count_d = 2'd0;
            mem0_d  = '0;
            mem1_d  = '0;
        end else begin
            case ({accept_s, pop})
                2'b01: begin
                    mem0_d  = mem1_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        mem0_d = din;
                    end else begin
                        mem1_d = din;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        mem0_d = din;
                    end else begin
                        mem0_d = mem1_q;
                        mem1_d = din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            count_q <= count_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
        end
    end

endmodule

// File: rtl/lpif_txrx_x8_asym2_full_master_link.sv
// Master-side LPIF endpoint: packs/filters TX flits into a skid, unpacks RX words, gated by link alignment.
module lpif_txrx_x8_asym2_full_master_link
    import lpif_x8_asym2_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk_wr,
    input  logic              rst_wr,
    input  logic              rx_online,
    input  logic [3:0]        dstrm_state,
    input  logic [1:0]        dstrm_protid,
    input  logic [127:0]      dstrm_data,
    input  logic              dstrm_dvalid,
    input  logic [7:0]        dstrm_crc,
    input  logic              dstrm_crc_valid,
    input  logic              dstrm_valid,
    output logic [144:0]      txfifo_downstream_data,
    output logic              txfifo_downstream_vld,
    input  logic              txfifo_downstream_rdy,
    input  logic [144:0]      rxfifo_upstream_data,
    input  logic              rxfifo_upstream_vld,
    output logic [3:0]        ustrm_state,
    output logic [1:0]        ustrm_protid,
    output logic [127:0]      ustrm_data,
    output logic              ustrm_dvalid,
    output logic [7:0]        ustrm_crc,
    output logic              ustrm_crc_valid,
    output logic              ustrm_valid,
    output logic              link_up,
    output logic              tx_overflow,
    output logic [CNT_W-1:0]  tx_drop_cnt
);

    link_st_e         state_q, state_d;
    logic [3:0]       last_state_q, last_state_d;
    lpif_flit_t       ustrm_q, ustrm_d;
    logic             tx_overflow_q, tx_overflow_d;
    logic [CNT_W-1:0] tx_drop_cnt_q, tx_drop_cnt_d;

    lpif_flit_t       tx_flit_s;
    lpif_flit_t       rx_flit_s;
    logic             clear_s;
    logic             push_s;
    logic             drop_s;
    logic             skid_full_s;
    logic             skid_pop_s;

    assign tx_flit_s = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                        dstrm_data, dstrm_protid, dstrm_state};
    assign rx_flit_s = lpif_flit_t'(rxfifo_upstream_data);

    // Link FSM. Buffers are wiped on the edge that enters FLUSH and again on the edge that
    // leaves it, so the whole FLUSH cycle already shows an empty skid and zeroed ustrm_*.
    always_comb begin
        state_d = state_q;
        clear_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_online) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (!rx_online) begin
                    state_d = FLUSH;
                    clear_s = 1'b1;
                end else begin
                    state_d = ACTIVE;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                clear_s = 1'b1;
            end
            default: begin
                state_d = IDLE;
                clear_s = 1'b1;
            end
        endcase
    end

    // TX push decision with idle-repeat suppression and drop accounting.
    always_comb begin
        push_s = (state_q == ACTIVE) && !clear_s &&
                 (dstrm_valid || dstrm_dvalid || dstrm_crc_valid || (dstrm_state != last_state_q));
        drop_s = push_s && skid_full_s && !skid_pop_s;
        if (clear_s) begin
            last_state_d = 4'h0;
        end else if (push_s) begin
            last_state_d = dstrm_state;
        end else begin
            last_state_d = last_state_q;
        end
        tx_overflow_d = tx_overflow_q | drop_s;
        if (drop_s && (tx_drop_cnt_q != {CNT_W{1'b1}})) begin
            tx_drop_cnt_d = tx_drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tx_drop_cnt_d = tx_drop_cnt_q;
        end
    end

    // RX unpack: capture on valid, otherwise hold payload and drop the qualifiers.
    always_comb begin
        if ((state_q == ACTIVE) && !clear_s) begin
            if (rxfifo_upstream_vld) begin
                ustrm_d = rx_flit_s;
            end else begin
                ustrm_d = clear_qualifiers(ustrm_q);
            end
        end else begin
            ustrm_d = '0;
        end
    end

    // All block state; synchronous reset overrides every other event.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state_q       <= IDLE;
            last_state_q  <= 4'h0;
            ustrm_q       <= '0;
            tx_overflow_q <= 1'b0;
            tx_drop_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_state_q  <= last_state_d;
            ustrm_q       <= ustrm_d;
            tx_overflow_q <= tx_overflow_d;
            tx_drop_cnt_q <= tx_drop_cnt_d;
        end
    end

    lpif_skid2 #(
        .W (FLIT_W)
    ) u_skid (
        .clk  (clk_wr),
        .rst  (rst_wr),
        .clr  (clear_s),
        .push (push_s),
        .din  (tx_flit_s),
        .rdy  (txfifo_downstream_rdy),
        .vld  (txfifo_downstream_vld),
        .full (skid_full_s),
        .pop  (skid_pop_s),
        .dout (txfifo_downstream_data)
    );

    assign link_up         = (state_q == ACTIVE);
    assign tx_overflow     = tx_overflow_q;
    assign tx_drop_cnt     = tx_drop_cnt_q;
    assign ustrm_state     = ustrm_q.state;
    assign ustrm_protid    = ustrm_q.protid;
    assign ustrm_data      = ustrm_q.data;
    assign ustrm_dvalid    = ustrm_q.dvalid;
    assign ustrm_crc       = ustrm_q.crc;
    assign ustrm_crc_valid = ustrm_q.crc_valid;
    assign ustrm_valid     = ustrm_q.valid;

endmodule

// File: tb/tb_lpif_txrx_x8_asym2_full_master_link.sv
// Bench for the master-side LPIF endpoint: vector table, hand sequences and a random run
// against a queue-based reference model.
module tb_lpif_txrx_x8_asym2_full_master_link;

    logic clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    logic         rst_wr, rx_online;
    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [127:0] dstrm_data;
    logic         dstrm_dvalid, dstrm_crc_valid, dstrm_valid;
    logic [7:0]   dstrm_crc;
    logic [144:0] txfifo_downstream_data;
    logic         txfifo_downstream_vld, txfifo_downstream_rdy;
    logic [144:0] rxfifo_upstream_data;
    logic         rxfifo_upstream_vld;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [127:0] ustrm_data;
    logic         ustrm_dvalid, ustrm_crc_valid, ustrm_valid;
    logic [7:0]   ustrm_crc;
    logic         link_up, tx_overflow;
    logic [15:0]  tx_drop_cnt;

    lpif_txrx_x8_asym2_full_master_link dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .rx_online(rx_online),
        .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
        .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
        .dstrm_valid(dstrm_valid),
        .txfifo_downstream_data(txfifo_downstream_data), .txfifo_downstream_vld(txfifo_downstream_vld),
        .txfifo_downstream_rdy(txfifo_downstream_rdy),
        .rxfifo_upstream_data(rxfifo_upstream_data), .rxfifo_upstream_vld(rxfifo_upstream_vld),
        .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
        .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
        .ustrm_valid(ustrm_valid), .link_up(link_up), .tx_overflow(tx_overflow),
        .tx_drop_cnt(tx_drop_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: link mode flags, a bounded queue for the skid, plain counters.
    logic [144:0] m_q[$];
    bit           m_active, m_flush, m_ovf;
    int           m_drops;
    logic [3:0]   m_last;
    logic [144:0] m_rx;

    typedef struct {
        bit         online;
        bit         valid;
        logic [3:0] st;
        logic [7:0] tag;
        bit         rdy;
        bit         e_link;
        bit         e_vld;
        logic [15:0] e_cnt;
        bit         chk_tag;
        logic [7:0] e_tag;
    } vec_t;

    vec_t vt[19];

    task automatic check(input string name, input logic [144:0] act, input logic [144:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [144:0] w;
        bit want;
        if (rst_wr) begin
            m_q.delete(); m_active = 0; m_flush = 0; m_ovf = 0; m_drops = 0; m_last = 4'h0; m_rx = '0;
        end else if (m_flush) begin
            m_flush = 0;
        end else if (m_active && !rx_online) begin
            m_active = 0; m_flush = 1; m_q.delete(); m_rx = '0; m_last = 4'h0;
        end else if (m_active) begin
            w = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid, dstrm_data, dstrm_protid, dstrm_state};
            want = dstrm_valid || dstrm_dvalid || dstrm_crc_valid || (dstrm_state != m_last);
            if (m_q.size() > 0 && txfifo_downstream_rdy) void'(m_q.pop_front());
            if (want) begin
                m_last = dstrm_state;
                if (m_q.size() < 2) m_q.push_back(w);
                else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (rxfifo_upstream_vld) m_rx = rxfifo_upstream_data;
            else begin
                m_rx[144] = 1'b0; m_rx[143] = 1'b0; m_rx[134] = 1'b0;
            end
        end else if (rx_online) begin
            m_active = 1;
        end
    endtask

    task automatic tick();
        logic [15:0] d16;
        model_step();
        @(posedge clk_wr);
        #1;
        d16 = m_drops[15:0];
        check("link_up", 145'(link_up), 145'(m_active));
        check("tx_vld", 145'(txfifo_downstream_vld), 145'(m_q.size() > 0));
        if (m_q.size() > 0) check("tx_data", txfifo_downstream_data, m_q[0]);
        check("ustrm", {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid, ustrm_data,
                        ustrm_protid, ustrm_state}, m_rx);
        check("tx_overflow", 145'(tx_overflow), 145'(m_ovf));
        check("tx_drop_cnt", 145'(tx_drop_cnt), 145'(d16));
    endtask

    task automatic set_tx(input bit v, input logic [3:0] st, input logic [7:0] tag, input bit rdy);
        dstrm_valid = v; dstrm_dvalid = 1'b0; dstrm_crc_valid = 1'b0; dstrm_state = st;
        dstrm_data = {16{tag}}; dstrm_crc = tag; dstrm_protid = 2'd1; txfifo_downstream_rdy = rdy;
    endtask

    task automatic check_head(input string name, input logic [7:0] tag);
        logic [127:0] exp;
        exp = {16{tag}};
        check(name, 145'(txfifo_downstream_data[133:6]), 145'(exp));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [144:0] rw;
        // online valid st   tag   rdy link vld cnt  chk tag
        vt[0]  = '{1, 0, 4'h0, 8'h00, 1, 1, 0, 16'd0, 0, 8'h00};
        vt[1]  = '{1, 1, 4'h0, 8'hA5, 1, 1, 1, 16'd0, 1, 8'hA5};
        vt[2]  = '{1, 0, 4'h0, 8'h00, 1, 1, 0, 16'd0, 0, 8'h00};
        vt[3]  = '{1, 0, 4'h3, 8'h00, 1, 1, 1, 16'd0, 0, 8'h00};
        for (int i = 4; i < 13; i++) vt[i] = '{1, 0, 4'h3, 8'h00, 1, 1, 0, 16'd0, 0, 8'h00};
        vt[13] = '{1, 1, 4'h3, 8'h11, 0, 1, 1, 16'd0, 1, 8'h11};
        vt[14] = '{1, 1, 4'h3, 8'h22, 0, 1, 1, 16'd0, 1, 8'h11};
        vt[15] = '{1, 1, 4'h3, 8'h33, 0, 1, 1, 16'd1, 1, 8'h11};
        vt[16] = '{1, 1, 4'h3, 8'h44, 0, 1, 1, 16'd2, 1, 8'h11};
        vt[17] = '{1, 0, 4'h3, 8'h00, 1, 1, 1, 16'd2, 1, 8'h22};
        vt[18] = '{1, 0, 4'h3, 8'h00, 1, 1, 0, 16'd2, 0, 8'h00};

        rst_wr = 1'b1; rx_online = 1'b0; set_tx(0, 4'h0, 8'h00, 1);
        rxfifo_upstream_data = '0; rxfifo_upstream_vld = 1'b0;
        tick(); tick();
        check("reset_link_up", 145'(link_up), 145'(1'b0));
        check("reset_tx_vld", 145'(txfifo_downstream_vld), 145'(1'b0));
        check("reset_ustrm_valid", 145'(ustrm_valid), 145'(1'b0));
        rst_wr = 1'b0;

        // Bring-up, idle suppression and backpressure from the vector table.
        for (int i = 0; i < 19; i++) begin
            rx_online = vt[i].online;
            set_tx(vt[i].valid, vt[i].st, vt[i].tag, vt[i].rdy);
            tick();
            check($sformatf("vec%0d_link", i), 145'(link_up), 145'(vt[i].e_link));
            check($sformatf("vec%0d_vld", i), 145'(txfifo_downstream_vld), 145'(vt[i].e_vld));
            check($sformatf("vec%0d_cnt", i), 145'(tx_drop_cnt), 145'(vt[i].e_cnt));
            if (vt[i].chk_tag) check_head($sformatf("vec%0d_head", i), vt[i].e_tag);
        end
        check("bringup_ovf", 145'(tx_overflow), 145'(1'b1));

        // Full skid with simultaneous push and pop: no drop, order kept.
        set_tx(1, 4'h3, 8'h55, 0); tick();
        set_tx(1, 4'h3, 8'h66, 0); tick();
        set_tx(1, 4'h3, 8'h77, 1); tick();
        check("full_pp_cnt", 145'(tx_drop_cnt), 145'(16'd2));
        check("full_pp_vld", 145'(txfifo_downstream_vld), 145'(1'b1));
        check_head("full_pp_head", 8'h66);
        set_tx(0, 4'h3, 8'h00, 0); tick();
        check_head("full_pp_hold", 8'h66);
        set_tx(0, 4'h3, 8'h00, 1); tick();
        check_head("full_pp_next", 8'h77);
        tick();
        check("full_pp_empty", 145'(txfifo_downstream_vld), 145'(1'b0));

        // RX unpack for one cycle, then hold with qualifiers cleared.
        rw = {1'b1, 1'b1, 8'h5C, 1'b1, rnd128(), 2'b10, 4'h9};
        rxfifo_upstream_data = rw; rxfifo_upstream_vld = 1'b1; tick();
        check("rx_crc", 145'(ustrm_crc), 145'(8'h5C));
        check("rx_protid", 145'(ustrm_protid), 145'(2'b10));
        check("rx_valid", 145'(ustrm_valid), 145'(1'b1));
        rxfifo_upstream_vld = 1'b0; rxfifo_upstream_data = '0; tick();
        check("rx_valid_drop", 145'(ustrm_valid), 145'(1'b0));
        check("rx_crc_hold", 145'(ustrm_crc), 145'(8'h5C));

        // Link loss with one word held.
        set_tx(1, 4'h3, 8'h88, 0); tick();
        check("loss_pre_vld", 145'(txfifo_downstream_vld), 145'(1'b1));
        rx_online = 1'b0; set_tx(0, 4'h3, 8'h00, 0); tick();
        check("flush_vld", 145'(txfifo_downstream_vld), 145'(1'b0));
        check("flush_crc", 145'(ustrm_crc), 145'(8'h00));
        check("flush_link", 145'(link_up), 145'(1'b0));
        tick();
        check("idle_link", 145'(link_up), 145'(1'b0));
        check("idle_cnt_kept", 145'(tx_drop_cnt), 145'(16'd2));
        rx_online = 1'b1; tick();
        check("relink", 145'(link_up), 145'(1'b1));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_wr          = ($urandom_range(0, 199) == 0);
            rx_online       = ($urandom_range(0, 99) < 96);
            dstrm_valid     = ($urandom_range(0, 3) == 0);
            dstrm_dvalid    = ($urandom_range(0, 7) == 0);
            dstrm_crc_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) dstrm_state = 4'($urandom_range(0, 15));
            dstrm_protid    = 2'($urandom_range(0, 3));
            dstrm_crc       = 8'($urandom_range(0, 255));
            dstrm_data      = rnd128();
            txfifo_downstream_rdy = ($urandom_range(0, 9) < 5);
            rxfifo_upstream_vld   = ($urandom_range(0, 1) == 1);
            rxfifo_upstream_data  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                     8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                                     rnd128(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            tick();
        end

        // Reset mid-transfer discards held words and sticky status.
        rst_wr = 1'b0; rx_online = 1'b1; rxfifo_upstream_vld = 1'b0;
        set_tx(0, 4'h0, 8'h00, 1); tick(); tick();
        set_tx(1, 4'h1, 8'h91, 0); tick();
        set_tx(1, 4'h1, 8'h92, 0); tick();
        set_tx(1, 4'h1, 8'h93, 0); tick();
        check("pre_rst_ovf", 145'(tx_overflow), 145'(1'b1));
        rst_wr = 1'b1; tick();
        check("rst_vld", 145'(txfifo_downstream_vld), 145'(1'b0));
        check("rst_ovf", 145'(tx_overflow), 145'(1'b0));
        check("rst_cnt", 145'(tx_drop_cnt), 145'(16'd0));
        check("rst_link", 145'(link_up), 145'(1'b0));
        rst_wr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
